// File: rtl/cursor_pkg.sv
// ---------------------------------------------------------------------------
// cursor_pkg
// Shared definitions for the cursor overlay generator:
//   - cursor_state_t : FSM state encoding (explicit 3-bit values)
//   - SHAPE_BOX / SHAPE_CROSS : footprint selector values
//   - OFS_W : width of the signed dx/dy scan offsets (covers -8..7)
//   - hold_cnt_width() : counter width for the hold-phase counters
// ---------------------------------------------------------------------------
package cursor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PASS_A = 3'd1,
        ST_HOLD_A = 3'd2,
        ST_PASS_B = 3'd3,
        ST_HOLD_B = 3'd4,
        ST_DONE   = 3'd5
    } cursor_state_t;

    localparam int SHAPE_BOX   = 0;
    localparam int SHAPE_CROSS = 1;

    // Radius is limited to 1..7, so a 4-bit signed offset is always enough.
    localparam int OFS_W = 4;

    // Width of a counter that runs 0..cycles-1.
    function automatic int hold_cnt_width(input int cycles);
        if (cycles <= 2)
            return 1;
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/cursor_offset_scan.sv
// ---------------------------------------------------------------------------
// cursor_offset_scan
// Raster offset counter for the cursor footprint. Walks dy = -R..R (outer)
// and dx = -R..R (inner), one step per cycle that 'advance' is high.
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-low reset
//   clear   in   restart the scan at dx = dy = -R (has priority)
//   advance in   step to the next candidate
//   dx, dy  out  signed offsets of the current candidate
//   last    out  high while the current candidate is dx = dy = R
// ---------------------------------------------------------------------------
module cursor_offset_scan
    import cursor_pkg::*;
#(
    parameter int RADIUS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    advance,
    output logic signed [OFS_W-1:0] dx,
    output logic signed [OFS_W-1:0] dy,
    output logic                    last
);

    localparam logic signed [OFS_W-1:0] R_POS = OFS_W'(RADIUS);
    localparam logic signed [OFS_W-1:0] R_NEG = OFS_W'(-RADIUS);
    localparam logic signed [OFS_W-1:0] ONE   = OFS_W'(1);

    // Accumulator-style raster: dx accumulates by one, and on wrap the row
    // accumulator dy takes the carry. After the final candidate the scan
    // wraps back to the top-left corner on its own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dx <= R_NEG;
            dy <= R_NEG;
        end else if (clear) begin
            dx <= R_NEG;
            dy <= R_NEG;
        end else if (advance) begin
            if (dx == R_POS) begin
                dx <= R_NEG;
                dy <= (dy == R_POS) ? R_NEG : dy + ONE;
            end else begin
                dx <= dx + ONE;
            end
        end
    end

    assign last = (dx == R_POS) && (dy == R_POS);

endmodule

// File: rtl/cursor_blink_gen.sv
// ---------------------------------------------------------------------------
// cursor_blink_gen
// Cursor overlay generator. On init it latches a centre and writes the
// cursor footprint in COLOR_A, holds ON_CYCLES, writes it again in COLOR_B,
// holds OFF_CYCLES and then pulses cursor_done for one cycle. Pixels outside
// 0..MAX_X / 0..MAX_Y are clipped. Writes use a ready/valid handshake.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   init         in   start request, sampled only in IDLE
//   in_x, in_y   in   cursor centre, latched on accepted init
//   paint_ready  in   write port accepts the current pixel
//   paint        out  pixel write valid
//   out_x, out_y out  pixel coordinates (0 when paint = 0)
//   px_data      out  pixel colour (0 when paint = 0)
//   cursor_done  out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module cursor_blink_gen
    import cursor_pkg::*;
#(
    parameter int                  COORD_W    = 6,
    parameter int                  MAX_X      = 63,
    parameter int                  MAX_Y      = 63,
    parameter int                  RADIUS     = 1,
    parameter int                  SHAPE      = SHAPE_BOX,
    parameter int                  COLOR_W    = 8,
    parameter logic [COLOR_W-1:0]  COLOR_A    = 8'hFF,
    parameter logic [COLOR_W-1:0]  COLOR_B    = 8'h00,
    parameter int                  ON_CYCLES  = 16,
    parameter int                  OFF_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    input  logic               paint_ready,
    output logic               paint,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [COLOR_W-1:0] px_data,
    output logic               cursor_done
);

    // Candidate coordinates need two extra bits: one for the sign of a
    // negative (clipped) result and one for overflow past the top of range.
    localparam int CW     = COORD_W + 2;
    localparam int HOLD_W = hold_cnt_width((ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES);

    localparam logic signed [CW-1:0]    MAX_XS   = CW'(MAX_X);
    localparam logic signed [CW-1:0]    MAX_YS   = CW'(MAX_Y);
    localparam logic signed [OFS_W-1:0] R_POS    = OFS_W'(RADIUS);
    localparam logic signed [OFS_W-1:0] R_NEG    = OFS_W'(-RADIUS);
    localparam logic [HOLD_W-1:0]       ON_LAST  = HOLD_W'(ON_CYCLES - 1);
    localparam logic [HOLD_W-1:0]       OFF_LAST = HOLD_W'(OFF_CYCLES - 1);

    cursor_state_t              state;
    logic [COORD_W-1:0]         x_l;
    logic [COORD_W-1:0]         y_l;
    logic [HOLD_W-1:0]          hold_cnt;

    logic signed [OFS_W-1:0]    dx;
    logic signed [OFS_W-1:0]    dy;
    logic                       last;
    logic                       scan_clear;
    logic                       scan_advance;

    logic signed [CW-1:0]       cx;
    logic signed [CW-1:0]       cy;
    logic                       in_pass;
    logic                       on_shape;
    logic                       in_bounds;
    logic                       emit;

    cursor_offset_scan #(
        .RADIUS (RADIUS)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .clear   (scan_clear),
        .advance (scan_advance),
        .dx      (dx),
        .dy      (dy),
        .last    (last)
    );

    // Shape and clip decode of the current candidate. Everything here is
    // derived from registered state only, so paint/out_x/out_y/px_data have
    // no combinational dependence on paint_ready or init.
    always_comb begin
        in_pass = (state == ST_PASS_A) || (state == ST_PASS_B);

        if (SHAPE == SHAPE_CROSS)
            on_shape = (dx == '0) ^ (dy == '0);
        else
            on_shape = (dx == R_POS) || (dx == R_NEG) || (dy == R_POS) || (dy == R_NEG);

        cx = $signed({2'b00, x_l}) + CW'(dx);
        cy = $signed({2'b00, y_l}) + CW'(dy);

        in_bounds = !cx[CW-1] && (cx <= MAX_XS) && !cy[CW-1] && (cy <= MAX_YS);
        emit      = in_pass && on_shape && in_bounds;

        // Skipped candidates move on every cycle; emitted ones wait for ready.
        scan_clear   = !in_pass;
        scan_advance = in_pass && (!emit || paint_ready);
    end

    // Output decode: zeros whenever no pixel is being offered.
    always_comb begin
        paint       = emit;
        out_x       = emit ? cx[COORD_W-1:0] : '0;
        out_y       = emit ? cy[COORD_W-1:0] : '0;
        px_data     = emit ? ((state == ST_PASS_A) ? COLOR_A : COLOR_B) : '0;
        cursor_done = (state == ST_DONE);
    end

    // Sequencer: latch the centre, run the two passes with their holds and
    // finish with a single DONE cycle. init is only looked at in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            x_l      <= '0;
            y_l      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    hold_cnt <= '0;
                    if (init) begin
                        x_l   <= in_x;
                        y_l   <= in_y;
                        state <= ST_PASS_A;
                    end
                end
                ST_PASS_A: begin
                    if (scan_advance && last) begin
                        hold_cnt <= '0;
                        state    <= ST_HOLD_A;
                    end
                end
                ST_HOLD_A: begin
                    if (hold_cnt == ON_LAST) begin
                        hold_cnt <= '0;
                        state    <= ST_PASS_B;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                ST_PASS_B: begin
                    if (scan_advance && last) begin
                        hold_cnt <= '0;
                        state    <= ST_HOLD_B;
                    end
                end
                ST_HOLD_B: begin
                    if (hold_cnt == OFF_LAST) begin
                        hold_cnt <= '0;
                        state    <= ST_DONE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cursor_blink_gen.sv
// ---------------------------------------------------------------------------
// tb_cursor_blink_gen
// Drives two configurations of cursor_blink_gen (R=1 box and R=2 crosshair)
// through directed and randomized runs and compares every cycle against a
// reference model built from the footprint rules with plain integer loops.
// ---------------------------------------------------------------------------
module tb_cursor_blink_gen;

    localparam int BOX_R    = 1;
    localparam int BOX_ON   = 4;
    localparam int BOX_OFF  = 3;
    localparam int CRS_R    = 2;
    localparam int CRS_ON   = 5;
    localparam int CRS_OFF  = 2;
    localparam int MAXC     = 63;

    logic       clk = 1'b0;
    logic       rst;
    logic       init;
    logic       sel;
    logic       paint_ready;
    logic [5:0] in_x;
    logic [5:0] in_y;

    logic       init_box, init_crs;
    logic       paint_box, paint_crs, done_box, done_crs;
    logic [5:0] ox_box, oy_box, ox_crs, oy_crs;
    logic [7:0] pd_box, pd_crs;

    logic        paint_m;
    logic        done_m;
    logic [19:0] pix_m;

    int vectors     = 0;
    int miscompares = 0;

    int cand_emit [25];
    int cand_x    [25];
    int cand_y    [25];
    int ncand;

    assign init_box = init & ~sel;
    assign init_crs = init & sel;

    always #5 clk = ~clk;

    always_comb begin
        paint_m = sel ? paint_crs : paint_box;
        done_m  = sel ? done_crs  : done_box;
        pix_m   = sel ? {ox_crs, oy_crs, pd_crs} : {ox_box, oy_box, pd_box};
    end

    cursor_blink_gen #(
        .COORD_W(6), .MAX_X(MAXC), .MAX_Y(MAXC), .RADIUS(BOX_R), .SHAPE(0),
        .COLOR_W(8), .COLOR_A(8'hFF), .COLOR_B(8'h00),
        .ON_CYCLES(BOX_ON), .OFF_CYCLES(BOX_OFF)
    ) dut_box (
        .clk(clk), .rst(rst), .init(init_box), .in_x(in_x), .in_y(in_y),
        .paint_ready(paint_ready), .paint(paint_box), .out_x(ox_box),
        .out_y(oy_box), .px_data(pd_box), .cursor_done(done_box)
    );

    cursor_blink_gen #(
        .COORD_W(6), .MAX_X(MAXC), .MAX_Y(MAXC), .RADIUS(CRS_R), .SHAPE(1),
        .COLOR_W(8), .COLOR_A(8'h5A), .COLOR_B(8'hC3),
        .ON_CYCLES(CRS_ON), .OFF_CYCLES(CRS_OFF)
    ) dut_crs (
        .clk(clk), .rst(rst), .init(init_crs), .in_x(in_x), .in_y(in_y),
        .paint_ready(paint_ready), .paint(paint_crs), .out_x(ox_crs),
        .out_y(oy_crs), .px_data(pd_crs), .cursor_done(done_crs)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Candidate list of one pass in raster order, straight from the footprint
    // rules: which offsets are on the shape and which land inside the frame.
    task automatic buildModel(input int x, input int y, input int r, input int shape);
        int dxa, dya, on, px, py;
        ncand = 0;
        for (int dyv = -r; dyv <= r; dyv++) begin
            for (int dxv = -r; dxv <= r; dxv++) begin
                dxa = (dxv < 0) ? -dxv : dxv;
                dya = (dyv < 0) ? -dyv : dyv;
                if (shape == 1)
                    on = ((dxv == 0) != (dyv == 0)) ? 1 : 0;
                else
                    on = (dxa == r || dya == r) ? 1 : 0;
                px = x + dxv;
                py = y + dyv;
                cand_emit[ncand] = (on == 1 && px >= 0 && px <= MAXC && py >= 0 && py <= MAXC) ? 1 : 0;
                cand_x[ncand]    = px;
                cand_y[ncand]    = py;
                ncand++;
            end
        end
    endtask

    // One full cursor sequence. mode: 0 ready always high, 1 random ready,
    // 2 ready low for 3 cycles on the second pixel. poke pulses init with
    // new coordinates during HOLD_A and during DONE. abort_b pulls reset
    // part-way into pass B.
    task automatic applyStimulus(input int x, input int y, input int mode,
                                 input bit poke, input bit abort_b);
        int r, shape, on_c, off_c;
        int phase, idx, hc, stalls, npix, cyc, e;
        logic [7:0]  ca, cb;
        logic        exp_p, exp_d;
        logic [19:0] exp_pix;

        r     = sel ? CRS_R : BOX_R;
        shape = sel ? 1 : 0;
        on_c  = sel ? CRS_ON : BOX_ON;
        off_c = sel ? CRS_OFF : BOX_OFF;
        ca    = sel ? 8'h5A : 8'hFF;
        cb    = sel ? 8'hC3 : 8'h00;
        buildModel(x, y, r, shape);

        @(negedge clk);
        in_x = 6'(x);
        in_y = 6'(y);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;

        phase  = 0;
        idx    = 0;
        hc     = 0;
        stalls = 3;
        npix   = 0;
        cyc    = 0;
        while (1) begin
            e       = 0;
            exp_p   = 1'b0;
            exp_d   = 1'b0;
            exp_pix = '0;
            if (phase == 0 || phase == 2) begin
                e = cand_emit[idx];
                if (e == 1) begin
                    exp_p   = 1'b1;
                    exp_pix = {6'(cand_x[idx]), 6'(cand_y[idx]), (phase == 0) ? ca : cb};
                end
            end
            if (phase == 4)
                exp_d = 1'b1;

            case (mode)
                1:       paint_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (exp_p && npix == 1 && stalls > 0) begin
                        paint_ready = 1'b0;
                        stalls--;
                    end else begin
                        paint_ready = 1'b1;
                    end
                end
                default: paint_ready = 1'b1;
            endcase

            init = 1'b0;
            if (poke && ((phase == 1 && hc == 1) || phase == 4)) begin
                init = 1'b1;
                in_x = 6'($urandom_range(0, MAXC));
                in_y = 6'($urandom_range(0, MAXC));
            end

            if (abort_b && phase == 2 && idx == 3) begin
                rst = 1'b0;
                #1;
                checkOutput("rst_paint", 32'(paint_m), 32'd0);
                checkOutput("rst_pixel", 32'(pix_m), 32'd0);
                checkOutput("rst_done", 32'(done_m), 32'd0);
                @(negedge clk);
                rst = 1'b1;
                return;
            end

            checkOutput("paint", 32'(paint_m), 32'(exp_p));
            checkOutput("pixel", 32'(pix_m), 32'(exp_pix));
            checkOutput("done", 32'(done_m), 32'(exp_d));

            if (phase == 4)
                break;

            case (phase)
                0, 2: begin
                    if (e == 0 || paint_ready) begin
                        if (e == 1)
                            npix++;
                        idx++;
                        if (idx == ncand) begin
                            phase++;
                            idx = 0;
                            hc  = 0;
                        end
                    end
                end
                1: begin
                    hc++;
                    if (hc == on_c)
                        phase = 2;
                end
                default: begin
                    hc++;
                    if (hc == off_c)
                        phase = 4;
                end
            endcase

            cyc++;
            if (cyc > 2000) begin
                checkOutput("cycle_budget", 32'd1, 32'd0);
                return;
            end
            @(negedge clk);
        end

        @(negedge clk);
        init = 1'b0;
        checkOutput("idle_paint", 32'(paint_m), 32'd0);
        checkOutput("idle_done", 32'(done_m), 32'd0);
    endtask

    initial begin
        rst         = 1'b0;
        init        = 1'b0;
        sel         = 1'b0;
        paint_ready = 1'b0;
        in_x        = '0;
        in_y        = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_box", {11'd0, paint_box, ox_box, oy_box, pd_box, done_box}, 32'd0);
        checkOutput("reset_crs", {11'd0, paint_crs, ox_crs, oy_crs, pd_crs, done_crs}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] box cursor, R=1");
        applyStimulus(10, 10, 0, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 1'b0, 1'b0);
        applyStimulus(63, 63, 1, 1'b0, 1'b0);
        applyStimulus(30, 20, 2, 1'b0, 1'b0);
        applyStimulus(12, 40, 0, 1'b1, 1'b0);
        applyStimulus(8, 8, 0, 1'b0, 1'b1);
        applyStimulus(20, 20, 0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            applyStimulus($urandom_range(0, MAXC), $urandom_range(0, MAXC), 1, 1'($urandom_range(0, 1)), 1'b0);

        sel = 1'b1;
        $display("[TB] crosshair cursor, R=2");
        applyStimulus(5, 5, 0, 1'b0, 1'b0);
        applyStimulus(0, 63, 1, 1'b0, 1'b0);
        applyStimulus(40, 1, 2, 1'b1, 1'b0);
        applyStimulus(33, 17, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            applyStimulus($urandom_range(0, MAXC), $urandom_range(0, MAXC), 1, 1'($urandom_range(0, 1)), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
